dm_port: RTL and testbench



---
 rtl/dm_port_if.sv | 33 +++
 rtl/dm_port.sv | 122 ++++++++++++
 tb/tb_dm_port.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_if.sv
// Data-memory port bus: program-sequencer/DAG request side and read/status return side.
interface dm_port_if;
  logic        ps_dm_en;
  logic        ps_dm_wrt_en;
  logic [15:0] dg_dm_add;
  logic [15:0] bc_dt;
  logic [15:0] dm_bc_dt;
  logic        dm_ps_rd_vld;
  logic        dm_ps_busy;
  logic        dm_ps_aerr;

  modport master (
    output ps_dm_en,
    output ps_dm_wrt_en,
    output dg_dm_add,
    output bc_dt,
    input  dm_bc_dt,
    input  dm_ps_rd_vld,
    input  dm_ps_busy,
    input  dm_ps_aerr
  );

  modport slave (
    input  ps_dm_en,
    input  ps_dm_wrt_en,
    input  dg_dm_add,
    input  bc_dt,
    output dm_bc_dt,
    output dm_ps_rd_vld,
    output dm_ps_busy,
    output dm_ps_aerr
  );
endinterface

// File: rtl/dm_port.sv
// Data-memory port: synchronous word array, one-entry posted write buffer with read forwarding,
// post-reset clear sequencer. Define DM_BOUNDS_EN to flag and suppress out-of-range accesses.
module dm_port #(
  parameter int unsigned ADDR_W = 8
) (
  input logic       clk,
  input logic       rst,
  dm_port_if.slave  bus
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                wb_valid_q;
  logic [ADDR_W-1:0]   wb_add_q;
  logic [15:0]         wb_dt_q;
  logic [15:0]         dt_q;
  logic                rd_vld_q;
  logic                busy_q;
  logic                aerr_q;

  logic [15:0]         mem [Depth];
  logic [ADDR_W-1:0]   idx;
  logic                fwd;
  logic                oob;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [15:0]         mem_wd;

  assign idx = bus.dg_dm_add[ADDR_W-1:0];
  assign fwd = wb_valid_q && (wb_add_q == idx);

`ifdef DM_BOUNDS_EN
  if (ADDR_W < 16) begin : g_bounds
    assign oob = |bus.dg_dm_add[15:ADDR_W];
  end else begin : g_no_bounds
    assign oob = 1'b0;
  end
`else
  // Upper address bits alias onto the array.
  assign oob = 1'b0;
  if (ADDR_W < 16) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^bus.dg_dm_add[15:ADDR_W];
  end
`endif

  // Single write port: the buffer is always empty during the clear, so the sources never collide.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wb_add_q;
    mem_wd = wb_dt_q;
    if (state_q == StClear) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt_q;
      mem_wd = '0;
    end else if (wb_valid_q) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_add_q   <= '0;
      wb_dt_q    <= '0;
      dt_q       <= '0;
      rd_vld_q   <= 1'b0;
      busy_q     <= 1'b1;
      aerr_q     <= 1'b0;
    end else begin
      rd_vld_q <= 1'b0;
      aerr_q   <= 1'b0;
      case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          // Drain happens via the write port; a new capture below re-arms the buffer.
          wb_valid_q <= 1'b0;
          if (bus.ps_dm_en) begin
            if (oob) begin
              aerr_q <= 1'b1;
              if (!bus.ps_dm_wrt_en) begin
                dt_q     <= '0;
                rd_vld_q <= 1'b1;
              end
            end else if (bus.ps_dm_wrt_en) begin
              wb_valid_q <= 1'b1;
              wb_add_q   <= idx;
              wb_dt_q    <= bus.bc_dt;
            end else begin
              dt_q     <= fwd ? wb_dt_q : mem[idx];
              rd_vld_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.dm_bc_dt     = dt_q;
  assign bus.dm_ps_rd_vld = rd_vld_q;
  assign bus.dm_ps_busy   = busy_q;
  assign bus.dm_ps_aerr   = aerr_q;

endmodule

// File: tb/tb_dm_port.sv
// Self-checking bench for dm_port: scoreboard of expected read data plus per-scenario checks.
module tb_dm_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_port_if bus ();

  dm_port #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          rd_cnt = 0;
  logic [15:0] exp_q[$];

  // Scoreboard monitor: every read-valid pulse pops one expected word.
  always @(posedge clk) begin : mon
    logic [15:0] e;
    #1;
    if (bus.dm_ps_rd_vld === 1'b1) begin
      rd_cnt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected: got rd_vld with data %h, required no read", bus.dm_bc_dt);
      end else begin
        e = exp_q.pop_front();
        if (bus.dm_bc_dt !== e) begin
          $display("FAIL rd_data: got %h, required %h", bus.dm_bc_dt, e);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic drive(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.ps_dm_en     = en;
    bus.ps_dm_wrt_en = wr;
    bus.dg_dm_add    = a;
    bus.bc_dt        = d;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e);
    drive(1'b1, 1'b0, a, 16'h0000);
    exp_q.push_back(e);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.dm_ps_busy === 1'b1 && n < 600);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    bus.ps_dm_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    n_chk++; if (bus.dm_bc_dt !== 16'h0000) $display("FAIL rst_dt: got %h, required 0000", bus.dm_bc_dt); else n_pass++;
    n_chk++; if (bus.dm_ps_rd_vld !== 1'b0) $display("FAIL rst_vld: got %b, required 0", bus.dm_ps_rd_vld); else n_pass++;
    n_chk++; if (bus.dm_ps_busy !== 1'b1) $display("FAIL rst_busy: got %b, required 1", bus.dm_ps_busy); else n_pass++;
    n_chk++; if (bus.dm_ps_aerr !== 1'b0) $display("FAIL rst_aerr: got %b, required 0", bus.dm_ps_aerr); else n_pass++;
    rst = 1'b0;
    wait_clear(n);
    n_chk++; if (n !== 256) $display("FAIL clear_len: got %0d edges, required 256", n); else n_pass++;
  endtask

  task automatic test_clear_read();
    rd(16'h0005, 16'h0000);
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_rd_vld !== 1'b1) $display("FAIL rd_lat: got vld %b, required 1", bus.dm_ps_rd_vld); else n_pass++;
    nop();
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_rd_vld !== 1'b0) $display("FAIL rd_pulse: got vld %b, required 0", bus.dm_ps_rd_vld); else n_pass++;
    n_chk++; if (bus.dm_bc_dt !== 16'h0000) $display("FAIL rd_hold: got %h, required 0000", bus.dm_bc_dt); else n_pass++;
  endtask

  task automatic test_forward();
    wr(16'h0010, 16'h1234);
    rd(16'h0010, 16'h1234);
    nop();
    nop();
    rd(16'h0010, 16'h1234);
    nop();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (exp_q.size() !== 0) $display("FAIL fwd_drain: got %0d pending reads, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c0 = rd_cnt;
    wr(16'h0020, 16'hAAAA);
    wr(16'h0021, 16'h5555);
    rd(16'h0020, 16'hAAAA);
    rd(16'h0021, 16'h5555);
    nop();
    @(posedge clk); #1;
    n_chk++; if (rd_cnt - c0 !== 2) $display("FAIL b2b_pulses: got %0d, required 2", rd_cnt - c0); else n_pass++;
  endtask

  task automatic test_reset_pending();
    int n;
    wr(16'h0030, 16'hBEEF);
    @(negedge clk);
    rst = 1'b1;
    bus.ps_dm_en = 1'b0;
    #1;
    n_chk++; if (bus.dm_ps_busy !== 1'b1) $display("FAIL rst_async: got busy %b, required 1", bus.dm_ps_busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(n);
    n_chk++; if (n !== 256) $display("FAIL clear_len2: got %0d edges, required 256", n); else n_pass++;
    rd(16'h0030, 16'h0000);
    nop();
    reset_pulse();
    repeat (100) @(posedge clk);
    #1;
    n_chk++; if (bus.dm_ps_busy !== 1'b1) $display("FAIL busy_mid: got %b, required 1", bus.dm_ps_busy); else n_pass++;
    reset_pulse();
    wait_clear(n);
    n_chk++; if (n !== 256) $display("FAIL clear_restart: got %0d edges, required 256", n); else n_pass++;
  endtask

  task automatic test_alias();
`ifdef DM_BOUNDS_EN
    wr(16'h0110, 16'h7777);
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_aerr !== 1'b1) $display("FAIL aerr_wr: got %b, required 1", bus.dm_ps_aerr); else n_pass++;
    nop();
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_aerr !== 1'b0) $display("FAIL aerr_pulse: got %b, required 0", bus.dm_ps_aerr); else n_pass++;
    rd(16'h0010, 16'h0000);
    rd(16'h0110, 16'h0000);
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_aerr !== 1'b1) $display("FAIL aerr_rd: got %b, required 1", bus.dm_ps_aerr); else n_pass++;
    nop();
`else
    wr(16'h0110, 16'h7777);
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_aerr !== 1'b0) $display("FAIL aerr_off_wr: got %b, required 0", bus.dm_ps_aerr); else n_pass++;
    rd(16'h0010, 16'h7777);
    @(posedge clk); #1;
    n_chk++; if (bus.dm_ps_aerr !== 1'b0) $display("FAIL aerr_off_rd: got %b, required 0", bus.dm_ps_aerr); else n_pass++;
    nop();
`endif
  endtask

  task automatic test_clear_requests();
    int n;
    int c0;
    reset_pulse();
    c0 = rd_cnt;
    repeat (9) @(posedge clk);
    wr(16'h0040, 16'h1111);
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    nop();
    wait_clear(n);
    n_chk++; if (n !== 245) $display("FAIL clear_tail: got %0d edges, required 245", n); else n_pass++;
    n_chk++; if (rd_cnt !== c0) $display("FAIL clear_vld: got %0d pulses, required %0d", rd_cnt, c0); else n_pass++;
    rd(16'h0040, 16'h0000);
    nop();
  endtask

  initial begin
    bus.ps_dm_en     = 1'b0;
    bus.ps_dm_wrt_en = 1'b0;
    bus.dg_dm_add    = 16'h0000;
    bus.bc_dt        = 16'h0000;
    test_reset();
    test_clear_read();
    test_forward();
    test_back_to_back();
    test_reset_pending();
    test_alias();
    test_clear_requests();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (exp_q.size() !== 0) $display("FAIL sb_empty: got %0d pending reads, required 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
